synfull_inject_queue: RTL and testbench
=======================================

Name: synfull_inject_queue

Overview:
- Synthesizable per-endpoint injection queue between a SynFull-style traffic source and one `packet_injector`.
- Holds requests in CLASS_NUM independent FIFOs, one per message class.
- Bypasses the queues when they are all empty and the injector is ready.
- Arbitrates round-robin among non-empty classes, supports stall or drop on overflow, and keeps injection statistics.

Parameters:
- CLASS_NUM, 2, number of message classes / queues (1..8).
- DEPTH, 16, entries per class queue (power of 2, ≥2).
- IDw, 32, request id width.
- PCK_SIZw, 8, packet size width in flits.
- NEw, 6, destination endpoint id width.
- OVF_MODE, "STALL", "STALL" deasserts req_ready on full; "DROP" accepts and discards.
- CNTw, 32, statistic counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  source request valid.
- req_class  in  log2(CLASS_NUM) (min 1)  request class.
- req_id  in  IDw  packet id.
- req_size  in  PCK_SIZw  packet size.
- req_dest  in  NEw  destination endpoint.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- inj_ready  in  1  injector can take a packet this cycle.
- inj_pck_wr  out  1  packet write strobe to injector.
- inj_id  out  IDw  data to injector.
- inj_size  out  PCK_SIZw  size to injector.
- inj_dest  out  NEw  destination id to injector.
- inj_class  out  log2(CLASS_NUM)  class_num to injector.
- occupancy  out  CLASS_NUM*(log2(DEPTH)+1)  per-class entry count.
- cnt_queued  out  CNTw  requests accepted (bypassed or stored).
- cnt_sent  out  CNTw  packets issued to injector.
- cnt_drop  out  CNTw  requests discarded (DROP mode).

Behaviour:
- Reset (reset=0, async): all queues empty, rr pointer=0, all counters=0, inj_pck_wr=0, occupancy=0; req_ready=1 once all queues are empty.
- Queues are first-word-fall-through. inj_* fields are driven combinationally from the selected head, or from req_* on bypass.
- Grant:
  - If any queue is non-empty, select the first non-empty class at or after rr pointer (wrapping).
  - inj_pck_wr = inj_ready & grant_valid; head popped on the same edge.
  - On pop, rr pointer ← granted class + 1 (mod CLASS_NUM); otherwise unchanged.
- Bypass:
  - Condition: all queues empty & req_valid & req_ready & inj_ready.
  - Effect: inj_pck_wr=1 with req_* fields in the same cycle (0-cycle latency); nothing stored.
- Store: an accepted request that is not bypassed is pushed to queue[req_class] at the clock edge. It becomes visible to the arbiter on the next cycle (1-cycle latency).
- Ordering: per-class FIFO order is preserved. No ordering is guaranteed across classes.
- Simultaneous push and pop on the same class: both happen; occupancy is unchanged. A full queue does not accept the push even if it pops in the same cycle.
- Full, STALL mode: req_ready = ~full[req_class], evaluated combinationally.
- Full, DROP mode: req_ready=1 always. A request to a full class is discarded and cnt_drop increments.
- Empty: no grant. inj_pck_wr=0 unless bypassing.
- req_class ≥ CLASS_NUM: treated as class CLASS_NUM-1.
- Counters saturate at all-ones (no wrap).
  - cnt_queued: +1 per accepted, non-dropped request.
  - cnt_sent: +1 per inj_pck_wr.
- Reset asserted mid-operation: all contents discarded immediately; outputs return to reset values.

Optional Feature:
- Macro SYNFULL_INJ_HWM_EN.
- When defined: adds output port hwm, width CLASS_NUM*(log2(DEPTH)+1), holding a per-class high-water mark of occupancy. Updated each cycle with max(hwm, next occupancy); cleared only by reset.
- When undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan:
- Bypass: queues empty, inj_ready=1, req_valid=1 with id=0x11, size=4, dest=3 → inj_pck_wr=1 in the same cycle with identical fields; occupancy stays 0; cnt_queued=cnt_sent=1.
- Queueing: inj_ready=0, push 3 class-0 requests (ids 1, 2, 3); then inj_ready=1 → occupancy[0]=3, then ids 1, 2, 3 issued on 3 consecutive cycles.
- Round-robin: class 0 and class 1 each hold 2 entries, inj_ready held at 1 → issue order 0, 1, 0, 1, starting from rr=0.
- STALL overflow: DEPTH=16, inj_ready=0, push 17 to class 1 → req_ready=0 on the 17th; occupancy[1]=16; cnt_drop=0.
- DROP overflow: OVF_MODE="DROP", same stimulus → req_ready stays 1; cnt_drop=1; cnt_queued=16.
- Reset mid-run: with 5 entries queued, pulse reset low for 1 cycle → occupancy=0, counters=0, no inj_pck_wr afterwards. With SYNFULL_INJ_HWM_EN defined, hwm=5 before the reset and 0 after it.

Source files
------------

// File: rtl/synfull_inject_queue.sv
// -----------------------------------------------------------------------------
// synfull_inject_queue
//
// Per-endpoint injection queue between a SynFull-style traffic source and one
// packet_injector. Requests are held in CLASS_NUM first-word-fall-through
// FIFOs, one per message class. A round-robin arbiter picks among the
// non-empty classes. When every queue is empty and the injector is ready, a
// request bypasses the storage and is issued in the same cycle.
//
// Optional feature macro: SYNFULL_INJ_HWM_EN
//   When defined, an extra output port `hwm` carries a per-class high-water
//   mark of occupancy. The mark is cleared only by reset.
//
// Ports
//   clk, reset            clock and asynchronous active-low reset
//   req_valid/class/id/size/dest, req_ready
//                         request handshake from the traffic source
//   inj_ready             injector can take a packet this cycle
//   inj_pck_wr, inj_id/size/dest/class
//                         packet write strobe and fields to the injector
//   occupancy             per-class entry count, class c in slice c*(log2(DEPTH)+1)
//   cnt_queued/sent/drop  saturating statistics counters
//   hwm                   (SYNFULL_INJ_HWM_EN only) per-class high-water mark
// -----------------------------------------------------------------------------
module synfull_inject_queue #(
   parameter int    CLASS_NUM = 2,
   parameter int    DEPTH     = 16,
   parameter int    IDw       = 32,
   parameter int    PCK_SIZw  = 8,
   parameter int    NEw       = 6,
   parameter string OVF_MODE  = "STALL",
   parameter int    CNTw      = 32,
   localparam int   CLSw      = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1,
   localparam int   OCCw      = $clog2(DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   input  logic [CLSw-1:0]           req_class,
   input  logic [IDw-1:0]            req_id,
   input  logic [PCK_SIZw-1:0]       req_size,
   input  logic [NEw-1:0]            req_dest,
   output logic                      req_ready,
   input  logic                      inj_ready,
   output logic                      inj_pck_wr,
   output logic [IDw-1:0]            inj_id,
   output logic [PCK_SIZw-1:0]       inj_size,
   output logic [NEw-1:0]            inj_dest,
   output logic [CLSw-1:0]           inj_class,
   output logic [CLASS_NUM*OCCw-1:0] occupancy,
   output logic [CNTw-1:0]           cnt_queued,
   output logic [CNTw-1:0]           cnt_sent,
   output logic [CNTw-1:0]           cnt_drop
`ifdef SYNFULL_INJ_HWM_EN
   ,
   output logic [CLASS_NUM*OCCw-1:0] hwm
`endif
);

   localparam int DEPw      = $clog2(DEPTH);
   localparam int ENTw      = IDw + PCK_SIZw + NEw;
   localparam bit DROP_MODE = (OVF_MODE == "DROP");

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [CNTw-1:0] sat_inc(input logic [CNTw-1:0] v, input logic en);
      if (en && (v != {CNTw{1'b1}})) begin
         return v + {{(CNTw-1){1'b0}}, 1'b1};
      end else begin
         return v;
      end
   endfunction

   logic [ENTw-1:0]      mem_r     [CLASS_NUM][DEPTH];
   logic [DEPw-1:0]      wr_ptr_r  [CLASS_NUM];
   logic [DEPw-1:0]      rd_ptr_r  [CLASS_NUM];
   logic [OCCw-1:0]      count_r   [CLASS_NUM];
   logic [OCCw-1:0]      cnt_nxt_s [CLASS_NUM];
   logic [CLSw-1:0]      rr_r;
   logic [CNTw-1:0]      cnt_queued_r;
   logic [CNTw-1:0]      cnt_sent_r;
   logic [CNTw-1:0]      cnt_drop_r;

   logic [CLASS_NUM-1:0] full_s;
   logic [CLASS_NUM-1:0] empty_s;
   logic [CLASS_NUM-1:0] push_vec_s;
   logic [CLASS_NUM-1:0] pop_vec_s;
   logic                 all_empty_s;
   logic [CLSw-1:0]      req_cls_s;
   logic                 cls_full_s;
   logic                 accept_s;
   logic                 bypass_s;
   logic                 push_en_s;
   logic                 drop_s;
   logic                 gnt_valid_s;
   logic [CLSw-1:0]      gnt_cls_s;
   logic                 pop_s;
   logic [CLSw-1:0]      rr_nxt_s;
   logic [ENTw-1:0]      head_s;

   // Queue status flags and out-of-range class folding.
   always_comb begin
      full_s  = '0;
      empty_s = '0;
      for (int c = 0; c < CLASS_NUM; c++) begin
         full_s[c]  = (count_r[c] == OCCw'(DEPTH));
         empty_s[c] = (count_r[c] == '0);
      end
      all_empty_s = &empty_s;
      if (int'(req_class) >= CLASS_NUM) begin
         req_cls_s = CLSw'(CLASS_NUM - 1);
      end else begin
         req_cls_s = req_class;
      end
      cls_full_s = full_s[req_cls_s];
   end

   // Request acceptance: STALL backpressures a full class, DROP always accepts.
   always_comb begin
      if (DROP_MODE) begin
         req_ready = 1'b1;
      end else begin
         req_ready = ~cls_full_s;
      end
      accept_s  = req_valid & req_ready;
      // Reset gating keeps the injector strobe quiet while reset is held.
      bypass_s  = reset & all_empty_s & accept_s & inj_ready;
      push_en_s = accept_s & ~bypass_s & ~cls_full_s;
      drop_s    = accept_s & cls_full_s;
   end

   // Round-robin arbiter: first non-empty class at or after rr_r, wrapping.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_cls_s   = '0;
      for (int i = 0; i < CLASS_NUM; i++) begin
         if (!gnt_valid_s && !empty_s[(int'(rr_r) + i) % CLASS_NUM]) begin
            gnt_valid_s = 1'b1;
            gnt_cls_s   = CLSw'((int'(rr_r) + i) % CLASS_NUM);
         end else begin
            gnt_valid_s = gnt_valid_s;
            gnt_cls_s   = gnt_cls_s;
         end
      end
      pop_s = reset & inj_ready & gnt_valid_s;
      if (gnt_cls_s == CLSw'(CLASS_NUM - 1)) begin
         rr_nxt_s = '0;
      end else begin
         rr_nxt_s = gnt_cls_s + {{(CLSw-1){1'b0}}, 1'b1};
      end
   end

   // Per-class push/pop decode and next occupancy.
   always_comb begin
      push_vec_s = '0;
      pop_vec_s  = '0;
      for (int c = 0; c < CLASS_NUM; c++) begin
         push_vec_s[c] = push_en_s && (req_cls_s == CLSw'(c));
         pop_vec_s[c]  = pop_s && (gnt_cls_s == CLSw'(c));
         cnt_nxt_s[c]  = count_r[c] + {{(OCCw-1){1'b0}}, push_vec_s[c]}
                                    - {{(OCCw-1){1'b0}}, pop_vec_s[c]};
      end
   end

   // Injector interface: bypass forwards the request, otherwise the granted head.
   always_comb begin
      head_s     = mem_r[gnt_cls_s][rd_ptr_r[gnt_cls_s]];
      inj_pck_wr = pop_s | bypass_s;
      if (bypass_s) begin
         inj_id    = req_id;
         inj_size  = req_size;
         inj_dest  = req_dest;
         inj_class = req_cls_s;
      end else begin
         inj_id    = head_s[ENTw-1 -: IDw];
         inj_size  = head_s[NEw +: PCK_SIZw];
         inj_dest  = head_s[NEw-1:0];
         inj_class = gnt_cls_s;
      end
   end

   // Entry storage; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      if (push_en_s) begin
         mem_r[req_cls_s][wr_ptr_r[req_cls_s]] <= {req_id, req_size, req_dest};
      end
   end

   // Queue pointers, occupancy, round-robin pointer and statistics.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < CLASS_NUM; c++) begin
            wr_ptr_r[c] <= '0;
            rd_ptr_r[c] <= '0;
            count_r[c]  <= '0;
         end
         rr_r         <= '0;
         cnt_queued_r <= '0;
         cnt_sent_r   <= '0;
         cnt_drop_r   <= '0;
      end else begin
         for (int c = 0; c < CLASS_NUM; c++) begin
            if (push_vec_s[c]) begin
               wr_ptr_r[c] <= wr_ptr_r[c] + {{(DEPw-1){1'b0}}, 1'b1};
            end else begin
               wr_ptr_r[c] <= wr_ptr_r[c];
            end
            if (pop_vec_s[c]) begin
               rd_ptr_r[c] <= rd_ptr_r[c] + {{(DEPw-1){1'b0}}, 1'b1};
            end else begin
               rd_ptr_r[c] <= rd_ptr_r[c];
            end
            count_r[c] <= cnt_nxt_s[c];
         end
         if (pop_s) begin
            rr_r <= rr_nxt_s;
         end else begin
            rr_r <= rr_r;
         end
         cnt_queued_r <= sat_inc(cnt_queued_r, push_en_s | bypass_s);
         cnt_sent_r   <= sat_inc(cnt_sent_r, inj_pck_wr);
         cnt_drop_r   <= sat_inc(cnt_drop_r, drop_s);
      end
   end

   // Flatten per-class counts onto the occupancy bus.
   always_comb begin
      occupancy = '0;
      for (int c = 0; c < CLASS_NUM; c++) begin
         occupancy[c*OCCw +: OCCw] = count_r[c];
      end
   end

   assign cnt_queued = cnt_queued_r;
   assign cnt_sent   = cnt_sent_r;
   assign cnt_drop   = cnt_drop_r;

`ifdef SYNFULL_INJ_HWM_EN
   logic [OCCw-1:0] hwm_r [CLASS_NUM];

   // High-water mark tracks the largest next-cycle occupancy seen.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < CLASS_NUM; c++) begin
            hwm_r[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CLASS_NUM; c++) begin
            if (cnt_nxt_s[c] > hwm_r[c]) begin
               hwm_r[c] <= cnt_nxt_s[c];
            end else begin
               hwm_r[c] <= hwm_r[c];
            end
         end
      end
   end

   // Flatten per-class marks onto the hwm bus.
   always_comb begin
      hwm = '0;
      for (int c = 0; c < CLASS_NUM; c++) begin
         hwm[c*OCCw +: OCCw] = hwm_r[c];
      end
   end
`endif

endmodule

// File: tb/tb_synfull_inject_queue.sv
// -----------------------------------------------------------------------------
// Testbench for synfull_inject_queue. Two instances share one stimulus stream:
// dut uses STALL overflow handling, dut_b uses DROP. Expected injector packets
// are pushed into a scoreboard queue by the stimulus; a negedge monitor pops
// and compares whenever dut asserts inj_pck_wr.
// -----------------------------------------------------------------------------
module tb_synfull_inject_queue;

   localparam int CLASS_NUM = 2;
   localparam int DEPTH     = 16;
   localparam int OCCw      = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [0:0]  req_class;
   logic [31:0] req_id;
   logic [7:0]  req_size;
   logic [5:0]  req_dest;
   logic        inj_ready;

   logic        req_ready, inj_pck_wr;
   logic [31:0] inj_id;
   logic [7:0]  inj_size;
   logic [5:0]  inj_dest;
   logic [0:0]  inj_class;
   logic [9:0]  occupancy;
   logic [31:0] cnt_queued, cnt_sent, cnt_drop;

   logic        req_ready_b, inj_pck_wr_b;
   logic [31:0] inj_id_b;
   logic [7:0]  inj_size_b;
   logic [5:0]  inj_dest_b;
   logic [0:0]  inj_class_b;
   logic [9:0]  occupancy_b;
   logic [31:0] cnt_queued_b, cnt_sent_b, cnt_drop_b;
`ifdef SYNFULL_INJ_HWM_EN
   logic [9:0]  hwm, hwm_b;
`endif

   synfull_inject_queue #(.CLASS_NUM(CLASS_NUM), .DEPTH(DEPTH), .OVF_MODE("STALL")) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_class(req_class),
      .req_id(req_id), .req_size(req_size), .req_dest(req_dest), .req_ready(req_ready),
      .inj_ready(inj_ready), .inj_pck_wr(inj_pck_wr), .inj_id(inj_id), .inj_size(inj_size),
      .inj_dest(inj_dest), .inj_class(inj_class), .occupancy(occupancy),
      .cnt_queued(cnt_queued), .cnt_sent(cnt_sent), .cnt_drop(cnt_drop)
`ifdef SYNFULL_INJ_HWM_EN
      , .hwm(hwm)
`endif
   );

   synfull_inject_queue #(.CLASS_NUM(CLASS_NUM), .DEPTH(DEPTH), .OVF_MODE("DROP")) dut_b (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_class(req_class),
      .req_id(req_id), .req_size(req_size), .req_dest(req_dest), .req_ready(req_ready_b),
      .inj_ready(inj_ready), .inj_pck_wr(inj_pck_wr_b), .inj_id(inj_id_b), .inj_size(inj_size_b),
      .inj_dest(inj_dest_b), .inj_class(inj_class_b), .occupancy(occupancy_b),
      .cnt_queued(cnt_queued_b), .cnt_sent(cnt_sent_b), .cnt_drop(cnt_drop_b)
`ifdef SYNFULL_INJ_HWM_EN
      , .hwm(hwm_b)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] id;
      logic [7:0]  size;
      logic [5:0]  dest;
      logic [0:0]  cls;
   } pkt_t;

   pkt_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic void push_exp(input logic [31:0] id, input logic [7:0] sz,
                                    input logic [5:0] dst, input logic [0:0] cls);
      pkt_t p;
      p.id = id; p.size = sz; p.dest = dst; p.cls = cls;
      exp_q.push_back(p);
   endfunction

   // Monitor: every injector write must match the oldest expected packet.
   always @(negedge clk) begin
      if (inj_pck_wr === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inj actual id %0h required no write", inj_id);
         end else begin
            pkt_t e;
            e = exp_q.pop_front();
            chk("inj_id", 64'(inj_id), 64'(e.id));
            chk("inj_size", 64'(inj_size), 64'(e.size));
            chk("inj_dest", 64'(inj_dest), 64'(e.dest));
            chk("inj_class", 64'(inj_class), 64'(e.cls));
         end
      end
   end

   // Drive one request for one cycle; called at posedge+1.
   task automatic send(input logic [0:0] cls, input logic [31:0] id, input logic [7:0] sz,
                       input logic [5:0] dst, input logic exp_ready);
      req_valid = 1'b1; req_class = cls; req_id = id; req_size = sz; req_dest = dst;
      @(negedge clk);
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_class = 1'b0; req_id = 32'h0;
      req_size = 8'h0; req_dest = 6'h0; inj_ready = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_occupancy", 64'(occupancy), 64'h0);
      chk("rst_cnt_queued", 64'(cnt_queued), 64'h0);
      chk("rst_cnt_sent", 64'(cnt_sent), 64'h0);
      chk("rst_cnt_drop", 64'(cnt_drop), 64'h0);
      chk("rst_inj_pck_wr", 64'(inj_pck_wr), 64'h0);
      chk("rst_req_ready", 64'(req_ready), 64'h1);
      @(posedge clk); #1;
      reset = 1'b1;

      // Bypass: empty queues, injector ready -> same-cycle issue
      inj_ready = 1'b1;
      push_exp(32'h11, 8'd4, 6'd3, 1'b0);
      send(1'b0, 32'h11, 8'd4, 6'd3, 1'b1);
      @(negedge clk);
      chk("byp_occupancy", 64'(occupancy), 64'h0);
      chk("byp_cnt_queued", 64'(cnt_queued), 64'd1);
      chk("byp_cnt_sent", 64'(cnt_sent), 64'd1);
      next_cycle();

      // Queueing: three class-0 entries then drain on consecutive cycles
      inj_ready = 1'b0;
      for (int i = 1; i <= 3; i++) send(1'b0, 32'(i), 8'd1, 6'd1, 1'b1);
      @(negedge clk);
      chk("q_occ0", 64'(occupancy[0 +: OCCw]), 64'd3);
      for (int i = 1; i <= 3; i++) push_exp(32'(i), 8'd1, 6'd1, 1'b0);
      next_cycle();
      inj_ready = 1'b1;
      repeat (3) next_cycle();
      @(negedge clk);
      chk("q_occ_after", 64'(occupancy), 64'h0);
      chk("q_cnt_sent", 64'(cnt_sent), 64'd4);
      chk("q_cnt_queued", 64'(cnt_queued), 64'd4);
      chk("q_drained", 64'(exp_q.size()), 64'd0);
      next_cycle();

      // Round-robin from rr=0: expect 0,1,0,1
      inj_ready = 1'b0;
      pulse_reset();
      send(1'b0, 32'h20, 8'd2, 6'd5, 1'b1);
      send(1'b1, 32'h30, 8'd3, 6'd6, 1'b1);
      send(1'b0, 32'h21, 8'd2, 6'd5, 1'b1);
      send(1'b1, 32'h31, 8'd3, 6'd6, 1'b1);
      push_exp(32'h20, 8'd2, 6'd5, 1'b0);
      push_exp(32'h30, 8'd3, 6'd6, 1'b1);
      push_exp(32'h21, 8'd2, 6'd5, 1'b0);
      push_exp(32'h31, 8'd3, 6'd6, 1'b1);
      inj_ready = 1'b1;
      repeat (4) next_cycle();
      @(negedge clk);
      chk("rr_cnt_sent", 64'(cnt_sent), 64'd4);
      chk("rr_drained", 64'(exp_q.size()), 64'd0);
      next_cycle();

      // Overflow: 17 pushes to class 1 with the injector stalled
      inj_ready = 1'b0;
      pulse_reset();
      for (int i = 0; i < 17; i++) begin
         req_valid = 1'b1; req_class = 1'b1; req_id = 32'h100 + 32'(i);
         req_size = 8'd1; req_dest = 6'd2;
         @(negedge clk);
         chk("stall_req_ready", 64'(req_ready), (i < 16) ? 64'h1 : 64'h0);
         chk("drop_req_ready", 64'(req_ready_b), 64'h1);
         next_cycle();
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk("stall_occ1", 64'(occupancy[OCCw +: OCCw]), 64'd16);
      chk("stall_cnt_drop", 64'(cnt_drop), 64'd0);
      chk("stall_cnt_queued", 64'(cnt_queued), 64'd16);
      chk("drop_occ1", 64'(occupancy_b[OCCw +: OCCw]), 64'd16);
      chk("drop_cnt_drop", 64'(cnt_drop_b), 64'd1);
      chk("drop_cnt_queued", 64'(cnt_queued_b), 64'd16);
      next_cycle();

      // Simultaneous push and pop on class 0 keeps occupancy
      pulse_reset();
      send(1'b0, 32'h40, 8'd7, 6'd9, 1'b1);
      push_exp(32'h40, 8'd7, 6'd9, 1'b0);
      push_exp(32'h41, 8'd8, 6'd10, 1'b0);
      inj_ready = 1'b1;
      send(1'b0, 32'h41, 8'd8, 6'd10, 1'b1);
      @(negedge clk);
      chk("pp_occ0", 64'(occupancy[0 +: OCCw]), 64'd1);
      next_cycle();
      @(negedge clk);
      chk("pp_occ_after", 64'(occupancy), 64'h0);
      chk("pp_cnt_queued", 64'(cnt_queued), 64'd2);
      chk("pp_cnt_sent", 64'(cnt_sent), 64'd2);
      next_cycle();

      // Reset mid-run with 5 entries queued
      inj_ready = 1'b0;
      pulse_reset();
      for (int i = 0; i < 5; i++) send(1'b0, 32'h50 + 32'(i), 8'd1, 6'd1, 1'b1);
      @(negedge clk);
      chk("mr_occ0", 64'(occupancy[0 +: OCCw]), 64'd5);
`ifdef SYNFULL_INJ_HWM_EN
      chk("mr_hwm0_before", 64'(hwm[0 +: OCCw]), 64'd5);
`endif
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("mr_occ_in_reset", 64'(occupancy), 64'h0);
      chk("mr_wr_in_reset", 64'(inj_pck_wr), 64'h0);
      next_cycle();
      reset = 1'b1;
      inj_ready = 1'b1;
      repeat (3) next_cycle();
      @(negedge clk);
      chk("mr_occ_after", 64'(occupancy), 64'h0);
      chk("mr_cnt_queued", 64'(cnt_queued), 64'd0);
      chk("mr_cnt_sent", 64'(cnt_sent), 64'd0);
`ifdef SYNFULL_INJ_HWM_EN
      chk("mr_hwm_after", 64'(hwm), 64'h0);
`endif
      chk("final_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
